// File: rtl/mc_pc_sequencer_if.sv
// Sequencer <-> datapath bundle: IR fields, branch flag, memory handshake,
// memory/IR/regfile strobes, two-step PC protocol strobes and status flags.
interface mc_pc_sequencer_if;
   logic [3:0] opcode;
   logic [5:0] func;
   logic       br_taken;
   logic       mem_ready;
   logic       mem_read;
   logic       mem_write;
   logic       i_or_d;
   logic       ir_write;
   logic       reg_write;
   logic       PCWrite;
   logic       PVSWrite;
   logic [1:0] PCSource;
   logic       wwd_valid;
   logic       num_inst_inc;
   logic       is_halted;
   logic       mem_err;

   modport master (
      input  opcode, func, br_taken, mem_ready,
      output mem_read, mem_write, i_or_d, ir_write, reg_write,
      output PCWrite, PVSWrite, PCSource,
      output wwd_valid, num_inst_inc, is_halted, mem_err
   );

   modport slave (
      output opcode, func, br_taken, mem_ready,
      input  mem_read, mem_write, i_or_d, ir_write, reg_write,
      input  PCWrite, PVSWrite, PCSource,
      input  wwd_valid, num_inst_inc, is_halted, mem_err
   );
endinterface

// File: rtl/mc_pc_sequencer.sv
// Multicycle control FSM for the TSC core: fetch/decode/execute/mem/wb/commit.
// Ports: clk, reset_n (async active-low), bus (mc_pc_sequencer_if.master).
module mc_pc_sequencer #(
   parameter int MEM_TIMEOUT = 255
) (
   input logic                clk,
   input logic                reset_n,
   mc_pc_sequencer_if.master  bus
);

   localparam logic [1:0] PCSRC_SEQ    = 2'd0;
   localparam logic [1:0] PCSRC_OFFSET = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [3:0] OP_ADI = 4'd4;
   localparam logic [3:0] OP_ORI = 4'd5;
   localparam logic [3:0] OP_LHI = 4'd6;
   localparam logic [3:0] OP_LWD = 4'd7;
   localparam logic [3:0] OP_SWD = 4'd8;
   localparam logic [3:0] OP_JMP = 4'd9;
   localparam logic [3:0] OP_JAL = 4'd10;
   localparam logic [3:0] OP_R   = 4'd15;

   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_COMMIT, S_HALT
   } state_t;

   state_t     state;
   logic [3:0] op_q;
   logic [5:0] func_q;
   logic [7:0] cnt;
   logic       taken_q;
   logic       err_q;
   logic       hlt_ret_q;

   logic is_r, is_br, is_alu, is_jpr, is_jrl, is_wwd, is_hlt;
   logic is_mem, is_wb_ex, is_jump, tmo_hit;

   assign is_r     = (op_q == OP_R);
   assign is_br    = (op_q[3:2] == 2'b00);
   assign is_alu   = is_r && (func_q[5:3] == 3'b000);
   assign is_jpr   = is_r && (func_q == FN_JPR);
   assign is_jrl   = is_r && (func_q == FN_JRL);
   assign is_wwd   = is_r && (func_q == FN_WWD);
   assign is_hlt   = is_r && (func_q == FN_HLT);
   assign is_mem   = (op_q == OP_LWD) || (op_q == OP_SWD);
   assign is_wb_ex = (op_q == OP_ADI) || (op_q == OP_ORI) ||
                     (op_q == OP_LHI) || is_alu || is_jrl;
   assign is_jump  = (op_q == OP_JMP) || (op_q == OP_JAL) ||
                     is_jpr || is_jrl;

   // Counter value of the last tolerated wait cycle; 0 disables the check.
   assign tmo_hit  = (MEM_TIMEOUT != 0) && (cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_INIT;
         op_q      <= '0;
         func_q    <= '0;
         cnt       <= '0;
         taken_q   <= 1'b0;
         err_q     <= 1'b0;
         hlt_ret_q <= 1'b0;
      end else begin
         hlt_ret_q <= 1'b0;
         unique case (state)
            S_INIT: begin
               cnt   <= '0;
               state <= S_IF;
            end
            S_IF: begin
               if (bus.mem_ready) begin
                  op_q   <= bus.opcode;
                  func_q <= bus.func;
                  state  <= S_ID;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= S_HALT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_ID: begin
               unique case (1'b1)
                  is_hlt: begin
                     hlt_ret_q <= 1'b1;
                     state     <= S_HALT;
                  end
                  (op_q == OP_JMP): state <= S_COMMIT;
                  (op_q == OP_JAL): state <= S_WB;
                  default:          state <= S_EX;
               endcase
            end
            S_EX: begin
               unique case (1'b1)
                  is_br: begin
                     taken_q <= bus.br_taken;
                     state   <= S_COMMIT;
                  end
                  is_mem: begin
                     cnt   <= '0;
                     state <= S_MEM;
                  end
                  is_wb_ex: state <= S_WB;
                  default:  state <= S_COMMIT;
               endcase
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  state <= (op_q == OP_LWD) ? S_WB : S_COMMIT;
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  state <= S_HALT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WB: state <= S_COMMIT;
            S_COMMIT: begin
               cnt   <= '0;
               state <= S_IF;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_INIT;
         endcase
      end
   end

   logic in_if, in_id, in_ex, in_mem, in_wb, in_commit, in_halt;

   assign in_if     = (state == S_IF);
   assign in_id     = (state == S_ID);
   assign in_ex     = (state == S_EX);
   assign in_mem    = (state == S_MEM);
   assign in_wb     = (state == S_WB);
   assign in_commit = (state == S_COMMIT);
   assign in_halt   = (state == S_HALT);

   assign bus.mem_read     = in_if || (in_mem && (op_q == OP_LWD));
   assign bus.mem_write    = in_mem && (op_q == OP_SWD);
   assign bus.i_or_d       = in_mem;
   assign bus.ir_write     = in_if && bus.mem_ready;
   assign bus.reg_write    = in_wb;
   assign bus.PCWrite      = (in_if && bus.mem_ready) || in_id;
   assign bus.PVSWrite     = in_commit;
   assign bus.wwd_valid    = in_ex && is_wwd;
   assign bus.num_inst_inc = in_commit || hlt_ret_q;
   assign bus.is_halted    = in_halt;
   assign bus.mem_err      = err_q;

   always_comb begin
      bus.PCSource = PCSRC_SEQ;
      if (in_id) begin
         bus.PCSource = PCSRC_OFFSET;
      end else if (in_commit) begin
         if (is_br && taken_q) bus.PCSource = PCSRC_OFFSET;
         else if (is_jump)     bus.PCSource = PCSRC_JUMP;
      end
   end

endmodule

// File: tb/tb_mc_pc_sequencer.sv
// Directed bench for mc_pc_sequencer: per-cycle output vectors per scenario.
// Inputs change at negedge; outputs are compared 1 ns later.
module tb_mc_pc_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mc_pc_sequencer_if bus();

   mc_pc_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // {mem_read,mem_write,i_or_d,ir_write,reg_write,PCWrite,PVSWrite,
   //  PCSource[1:0],wwd_valid,num_inst_inc,is_halted,mem_err}
   logic [12:0] obs;
   assign obs = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                 bus.reg_write, bus.PCWrite, bus.PVSWrite, bus.PCSource,
                 bus.wwd_valid, bus.num_inst_inc, bus.is_halted,
                 bus.mem_err};

   localparam logic [12:0] V_NONE = 13'b0;
   localparam logic [12:0] V_IFR  = 13'b1_0_0_1_0_1_0_00_0_0_0_0;
   localparam logic [12:0] V_IFW  = 13'b1_0_0_0_0_0_0_00_0_0_0_0;
   localparam logic [12:0] V_ID   = 13'b0_0_0_0_0_1_0_01_0_0_0_0;
   localparam logic [12:0] V_WWD  = 13'b0_0_0_0_0_0_0_00_1_0_0_0;
   localparam logic [12:0] V_WB   = 13'b0_0_0_0_1_0_0_00_0_0_0_0;
   localparam logic [12:0] V_CSEQ = 13'b0_0_0_0_0_0_1_00_0_1_0_0;
   localparam logic [12:0] V_COFF = 13'b0_0_0_0_0_0_1_01_0_1_0_0;
   localparam logic [12:0] V_CJMP = 13'b0_0_0_0_0_0_1_10_0_1_0_0;
   localparam logic [12:0] V_MLW  = 13'b1_0_1_0_0_0_0_00_0_0_0_0;
   localparam logic [12:0] V_MSW  = 13'b0_1_1_0_0_0_0_00_0_0_0_0;
   localparam logic [12:0] V_HLT1 = 13'b0_0_0_0_0_0_0_00_0_1_1_0;
   localparam logic [12:0] V_HLT  = 13'b0_0_0_0_0_0_0_00_0_0_1_0;
   localparam logic [12:0] V_ERR  = 13'b0_0_0_0_0_0_0_00_0_0_1_1;

   task automatic test_reset();
      bus.mem_ready = 1'b1;
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (obs !== V_NONE) begin
            bad++;
            $display("FAIL reset_hold cyc%0d got=%b want=%b", i, obs, V_NONE);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      total++;
      if (obs !== V_NONE) begin
         bad++;
         $display("FAIL reset_init got=%b want=%b", obs, V_NONE);
      end
      @(negedge clk);
   endtask

   task automatic test_adi();
      logic [12:0] ev[$];
      ev = {V_IFR, V_ID, V_NONE, V_WB, V_CSEQ};
      bus.opcode = 4'd4;
      bus.func = 6'd0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL adi cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [12:0] ev[$];
      bit          bq[$];
      ev = {V_IFR, V_ID, V_NONE, V_COFF, V_IFR, V_ID, V_NONE, V_CSEQ};
      bq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      bus.opcode = 4'd1;
      bus.func = 6'd0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         bus.br_taken = bq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL beq cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
      bus.br_taken = 1'b0;
   endtask

   // Ready arrives on the 4th MEM cycle, the same cycle the timeout would fire.
   task automatic test_lwd_wait();
      logic [12:0] ev[$];
      bit          rq[$];
      ev = {V_IFR, V_ID, V_NONE, V_MLW, V_MLW, V_MLW, V_MLW, V_WB, V_CSEQ};
      rq = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.opcode = 4'd7;
      bus.func = 6'd0;
      for (int i = 0; i < ev.size(); i++) begin
         bus.mem_ready = rq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL lwd cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_jal_swd();
      logic [12:0] ev[$];
      logic [3:0]  oq[$];
      ev = {V_IFR, V_ID, V_WB, V_CJMP,
            V_IFR, V_ID, V_NONE, V_MSW, V_CSEQ};
      oq = {4'd10, 4'd10, 4'd10, 4'd10, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
      bus.func = 6'd0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         bus.opcode = oq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL jal_swd cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   // WWD, JRL, JPR, unknown opcode 12, JMP, R-ALU ADD in sequence.
   task automatic test_back_to_back();
      logic [12:0] ev[$];
      logic [3:0]  oq[$];
      logic [5:0]  fq[$];
      ev = {V_IFR, V_ID, V_WWD, V_CSEQ,
            V_IFR, V_ID, V_NONE, V_WB, V_CJMP,
            V_IFR, V_ID, V_NONE, V_CJMP,
            V_IFR, V_ID, V_NONE, V_CSEQ,
            V_IFR, V_ID, V_CJMP,
            V_IFR, V_ID, V_NONE, V_WB, V_CSEQ};
      oq = {4'd15, 4'd15, 4'd15, 4'd15,
            4'd15, 4'd15, 4'd15, 4'd15, 4'd15,
            4'd15, 4'd15, 4'd15, 4'd15,
            4'd12, 4'd12, 4'd12, 4'd12,
            4'd9, 4'd9, 4'd9,
            4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      fq = {6'd28, 6'd28, 6'd28, 6'd28,
            6'd26, 6'd26, 6'd26, 6'd26, 6'd26,
            6'd25, 6'd25, 6'd25, 6'd25,
            6'd0, 6'd0, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
      bus.mem_ready = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         bus.opcode = oq[i];
         bus.func = fq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL b2b cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_hlt();
      logic [12:0] ev[$];
      ev = {V_IFR, V_ID, V_HLT1};
      for (int i = 0; i < 20; i++) ev.push_back(V_HLT);
      bus.opcode = 4'd15;
      bus.func = 6'd29;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL hlt cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      logic [12:0] ev[$];
      bit          rq[$];
      ev = {V_NONE, V_IFW, V_IFW, V_IFW, V_IFW, V_ERR, V_ERR, V_ERR, V_ERR};
      rq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.opcode = 4'd4;
      bus.func = 6'd0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         bus.mem_ready = rq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL timeout cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [12:0] ev[$];
      bit          rq[$];
      ev = {V_NONE, V_IFR, V_ID, V_NONE, V_MLW};
      rq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.opcode = 4'd7;
      bus.func = 6'd0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < ev.size(); i++) begin
         bus.mem_ready = rq[i];
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL rmid_pre cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         if (i < ev.size() - 1) @(negedge clk);
      end
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if (obs !== V_NONE) begin
         bad++;
         $display("FAIL rmid_async got=%b want=%b", obs, V_NONE);
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (obs !== V_NONE) begin
         bad++;
         $display("FAIL rmid_hold got=%b want=%b", obs, V_NONE);
      end
      @(negedge clk);
      reset_n = 1'b1;
      ev = {V_NONE, V_IFR, V_ID, V_NONE};
      for (int i = 0; i < ev.size(); i++) begin
         #1;
         total++;
         if (obs !== ev[i]) begin
            bad++;
            $display("FAIL rmid_post cyc%0d got=%b want=%b", i, obs, ev[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bus.opcode = 4'd0;
      bus.func = 6'd0;
      bus.br_taken = 1'b0;
      bus.mem_ready = 1'b0;
      test_reset();
      test_adi();
      test_branch();
      test_lwd_wait();
      test_jal_swd();
      test_back_to_back();
      test_hlt();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
